// File: rtl/risc_mem_pkg.sv
// Shared types and helpers for the memory port arbiter: FSM states,
// store/load size encodings and the access legality predicates.
package risc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_LS_BUSY = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  // storeCtrl encodings
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // loadCtrl encodings
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic ls_misaligned(input logic       we,
                                         input logic [1:0] store_ctrl,
                                         input logic [2:0] load_ctrl,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (we) begin
      case (store_ctrl)
        SIZE_H:  mis = addr_lo[0];
        SIZE_W:  mis = |addr_lo;
        default: mis = 1'b0;
      endcase
    end else begin
      case (load_ctrl)
        LD_LH, LD_LHU: mis = addr_lo[0];
        LD_LW:         mis = |addr_lo;
        default:       mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

  // Size encodings with no defined meaning.
  function automatic logic ls_illegal(input logic       we,
                                      input logic [1:0] store_ctrl,
                                      input logic [2:0] load_ctrl);
    logic ill;
    if (we) begin
      ill = (store_ctrl == 2'b11);
    end else begin
      case (load_ctrl)
        LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: ill = 1'b0;
        default:                             ill = 1'b1;
      endcase
    end
    return ill;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword lane of a read word and extends it
// to 32 bits according to the load size.
module mem_load_align
  import risc_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  loadCtrl,
  output logic [31:0] ext_data
);

  logic [31:0] lane;

  // Shift the addressed lane down to bit 0, then extend by load size.
  always_comb begin
    lane     = rdata >> {addr, 3'b000};
    ext_data = 32'h0;
    case (loadCtrl)
      LD_LB:   ext_data = {{24{lane[7]}}, lane[7:0]};
      LD_LH:   ext_data = {{16{lane[15]}}, lane[15:0]};
      LD_LW:   ext_data = rdata;
      LD_LBU:  ext_data = {24'h0, lane[7:0]};
      LD_LHU:  ext_data = {16'h0, lane[15:0]};
      default: ext_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store. One
// registered transaction at a time; load/store has priority except that a
// run of MAX_LS_RUN consecutive LS grants with fetch waiting yields to fetch.
module mem_port_arbiter
  import risc_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_LS_RUN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_rdata,
  output logic                  if_ack,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  input  logic [1:0]            ls_storeCtrl,
  input  logic [2:0]            ls_loadCtrl,
  output logic [31:0]           ls_rdata,
  output logic                  ls_ack,
  output logic                  ls_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);

  localparam logic [3:0] MAX_RUN = 4'(MAX_LS_RUN);

  arb_state_e            state_q;
  logic [3:0]            run_cnt_q;
  logic                  mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [3:0]            mem_be_q;
  logic [31:0]           if_rdata_q, ls_rdata_q;
  logic                  if_ack_q, ls_ack_q, ls_err_q;

  logic        grant_ls, ls_bad;
  logic [3:0]  st_be_d;
  logic [31:0] st_wdata_d;
  logic [31:0] ld_data;

  // ls_addr/ls_loadCtrl are held stable until ack, so align straight from them.
  mem_load_align u_align (
    .rdata    (mem_rdata),
    .addr     (ls_addr[1:0]),
    .loadCtrl (ls_loadCtrl),
    .ext_data (ld_data)
  );

  // Grant decision, error detection and store lane formatting.
  always_comb begin
    grant_ls   = ls_req && !(if_req && (run_cnt_q == MAX_RUN));
    ls_bad     = ls_misaligned(ls_we, ls_storeCtrl, ls_loadCtrl, ls_addr[1:0]) ||
                 ls_illegal(ls_we, ls_storeCtrl, ls_loadCtrl);
    st_be_d    = 4'b0000;
    st_wdata_d = ls_wdata;
    case (ls_storeCtrl)
      SIZE_B: begin
        st_be_d    = 4'b0001 << ls_addr[1:0];
        st_wdata_d = {4{ls_wdata[7:0]}};
      end
      SIZE_H: begin
        st_be_d    = ls_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata_d = {2{ls_wdata[15:0]}};
      end
      SIZE_W: begin
        st_be_d    = 4'b1111;
        st_wdata_d = ls_wdata;
      end
      default: begin
        st_be_d    = 4'b0000;
        st_wdata_d = ls_wdata;
      end
    endcase
  end

  // Arbitration FSM with all outputs registered; acks are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      run_cnt_q   <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
      if_rdata_q  <= 32'h0;
      ls_rdata_q  <= 32'h0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      ls_err_q    <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      ls_ack_q <= 1'b0;
      ls_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_ls) begin
            run_cnt_q <= if_req ? 4'(run_cnt_q + 4'd1) : 4'd0;
            if (ls_bad) begin
              ls_ack_q   <= 1'b1;
              ls_err_q   <= 1'b1;
              ls_rdata_q <= 32'h0;
              state_q    <= ST_RESP;
            end else begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= ls_we;
              mem_addr_q <= {ls_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_be_q   <= ls_we ? st_be_d : 4'b0000;
              if (ls_we) mem_wdata_q <= st_wdata_d;
              state_q    <= ST_LS_BUSY;
            end
          end else if (if_req) begin
            run_cnt_q  <= 4'd0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {if_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be_q   <= 4'b0000;
            state_q    <= ST_IF_BUSY;
          end
        end
        ST_IF_BUSY: begin
          if (mem_ready) begin
            mem_req_q  <= 1'b0;
            if_rdata_q <= mem_rdata;
            if_ack_q   <= 1'b1;
            state_q    <= ST_RESP;
          end
        end
        ST_LS_BUSY: begin
          if (mem_ready) begin
            mem_req_q  <= 1'b0;
            ls_rdata_q <= ld_data;
            ls_ack_q   <= 1'b1;
            state_q    <= ST_RESP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_ack    = ls_ack_q;
  assign ls_err    = ls_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing controller that shares the core's single memory port between instruction fetch and the load/store path. It arbitrates, issues one registered memory transaction at a time and waits on `mem_ready`. For stores it generates byte enables and lane-replicated write data from `storeCtrl`. For loads it aligns and sign- or zero-extends read data from `loadCtrl`. It sits between the fetch stage, the decoder/datapath load/store signals, and the external memory interface.

## Interface
- `ADDR_WIDTH`, default 32: address width of all address ports.
- `MAX_LS_RUN`, default 4: maximum consecutive load/store grants while fetch is waiting. Range 1..15.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_ack`.
- `if_addr` in ADDR_WIDTH: fetch byte address. Bits [1:0] are ignored; fetch is always a word access.
- `if_rdata` out 32: fetched word, valid when `if_ack`.
- `if_ack` out 1: one-cycle completion pulse.
- `ls_req` in 1: load/store request; held with all `ls_*` inputs stable until `ls_ack`.
- `ls_we` in 1: 1 = store (decoder `memWrite`), 0 = load.
- `ls_addr` in ADDR_WIDTH: byte address.
- `ls_wdata` in 32: store data, right-aligned.
- `ls_storeCtrl` in 2: 00 = SB, 01 = SH, 10 = SW, 11 = illegal.
- `ls_loadCtrl` in 3: 000 = LB, 001 = LH, 010 = LW, 100 = LBU, 101 = LHU; any other value is illegal.
- `ls_rdata` out 32: extended load result, valid when `ls_ack`.
- `ls_ack` out 1: one-cycle completion pulse.
- `ls_err` out 1: asserted together with `ls_ack` when the access is misaligned or has an illegal size.
- `mem_req` out 1: memory transaction valid.
- `mem_we` out 1: memory write.
- `mem_addr` out ADDR_WIDTH: word-aligned address; bits [1:0] are always 0.
- `mem_wdata` out 32: write data, lane-replicated.
- `mem_be` out 4: byte enables; 0000 on reads.
- `mem_rdata` in 32: read word, valid on the `mem_ready` cycle.
- `mem_ready` in 1: transaction completes on any cycle where `mem_req && mem_ready`.

## Operation
- The FSM has four states: IDLE, IF_BUSY, LS_BUSY, RESP. All outputs are registered.
- **IDLE, grant decision:**
  - Grant LS if `ls_req` is high, unless `if_req` is also high and `run_cnt == MAX_LS_RUN`; in that case grant IF.
  - Grant IF if only `if_req` is high.
  - Stay in IDLE if neither request is high.
- **`run_cnt` (4 bits):**
  - Incremented on an LS grant while `if_req` is high.
  - Cleared on an IF grant, or on an LS grant while `if_req` is low.
- **LS grant with an error:** a misaligned access (SH/LH/LHU with `addr[0]=1`; SW/LW with `addr[1:0]≠0`) or an illegal size skips memory. The FSM goes directly to RESP with `ls_ack=1`, `ls_err=1`, `ls_rdata=0`.
- **Normal grant:**
  - Register `mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}`, `mem_we`, `mem_be`, `mem_wdata`.
  - Assert `mem_req` and move to IF_BUSY or LS_BUSY.
- **IF_BUSY / LS_BUSY:** hold all `mem_*` outputs stable until `mem_ready`. On that cycle, capture the processed read data, drop `mem_req`, and go to RESP.
- **RESP:** pulse exactly one of `if_ack`/`ls_ack` for one cycle, then return to IDLE. No grant is made in RESP, so requesters have one cycle to drop or replace their request.
- **Store formatting:**
  - SB: `be = 4'b0001 << addr[1:0]`; `wdata = {4{wdata[7:0]}}`.
  - SH: `be = addr[1] ? 4'b1100 : 4'b0011`; `wdata = {2{wdata[15:0]}}`.
  - SW: `be = 4'b1111`; `wdata` passes through unchanged.
- **Load formatting:**
  - Select the lane as `mem_rdata >> (8*addr[1:0])`.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through unchanged.
- **Reset:** a reset in any state, including mid-transaction, returns the FSM to IDLE.
  - `mem_req`, `mem_we`, `if_ack`, `ls_ack`, `ls_err` = 0.
  - `mem_be` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `ls_rdata` = 0.
  - `run_cnt` = 0.
  - An abandoned memory transaction is not completed; memory must tolerate `mem_req` dropping without `mem_ready`.

## Timing
- A request sampled in IDLE at cycle 0 drives `mem_req=1` at cycle 1.
- With `mem_ready` high at cycle 1, the ack (with data) comes at cycle 2 and the next grant can be made at cycle 3.
- Minimum latency is 2 cycles per access; maximum throughput is one access per 3 cycles.
- Each `mem_ready` wait cycle adds exactly one cycle of latency.
- An error access acks at cycle 1.
- `mem_ready` is ignored while `mem_req=0`.
- A request dropped before ack is protocol misuse; behaviour is undefined, and the bench asserts it never happens.

## Structure
- Shared package `risc_mem_pkg` holds:
  - the state enum;
  - the SIZE_B/H/W storeCtrl encodings;
  - the LB/LH/LW/LBU/LHU loadCtrl constants;
  - the misalignment predicate function.
- Combinational sub-module `mem_load_align`: inputs `rdata`, `addr[1:0]`, `loadCtrl`; output is the extended 32-bit result.

## Test plan
- **LW:** `ls_req` LW at 0x100, memory returns 0xDEADBEEF with `mem_ready` on the first cycle -> `mem_addr=0x100`, `mem_be=0000`, `ls_ack` at cycle 2, `ls_rdata=0xDEADBEEF`.
- **SB:** SB at 0x203 with `ls_wdata=0x000000A5` -> `mem_be=1000`, `mem_wdata=0xA5A5A5A5`, `mem_addr=0x200`.
- **LB/LBU:** LB and LBU at 0x302, memory returns 0x12805634 -> LB gives 0xFFFFFF80, LBU gives 0x00000080.
- **Misaligned:** LH at 0x401 -> no `mem_req`, `ls_ack=1` and `ls_err=1` at cycle 1, `ls_rdata=0`.
- **Starvation guard:** `if_req` and `ls_req` held continuously with `MAX_LS_RUN=4` -> grant order is LS, LS, LS, LS, IF, then repeats.
- **Reset mid-transaction:** `rst` asserted in LS_BUSY with `mem_ready` low -> the next cycle shows IDLE, all outputs 0, and no ack ever pulses for the aborted access.
